// File: rtl/rf_scoreboard.sv
// Purpose: tracks outstanding long-latency register writes and gates decode issue on RAW/WAW/capacity hazards.
// Latency: o_issue_ready is combinational (zero cycles); busy/inflight/err update one cycle after issue or writeback.
// Backpressure: o_issue_ready low stalls decode; the writeback port is never stalled and must only retire tracked writes.
module rf_scoreboard #(
  parameter bit BYPASS_EN    = 1'b0,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic        i_issue_rs1_ren,
  input  logic [4:0]  i_issue_rs1,
  input  logic        i_issue_rs2_ren,
  input  logic [4:0]  i_issue_rs2,
  input  logic        i_issue_rd_wen,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_issue_long,
  output logic        o_issue_ready,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  output logic [31:0] o_busy,
  output logic [3:0]  o_inflight,
  output logic        o_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        err_q;

  logic clr, track, fire, set;
  logic raw1, raw2, waw, full;
  logic bypass1, bypass2;

  assign o_busy     = busy_q;
  assign o_inflight = inflight_q;
  assign o_err      = err_q;

  // Legal writeback retires a pending destination; a new long write to a real rd gets tracked.
  assign clr   = i_wb_valid && (i_wb_rd != 5'd0) && busy_q[i_wb_rd];
  assign track = i_issue_long && i_issue_rd_wen && (i_issue_rd != 5'd0);

  // Same-cycle writeback only releases a read when the register file forwards write data.
  assign bypass1 = BYPASS_EN && clr && (i_wb_rd == i_issue_rs1);
  assign bypass2 = BYPASS_EN && clr && (i_wb_rd == i_issue_rs2);

  assign raw1 = i_issue_rs1_ren && (i_issue_rs1 != 5'd0) && busy_q[i_issue_rs1] && !bypass1;
  assign raw2 = i_issue_rs2_ren && (i_issue_rs2 != 5'd0) && busy_q[i_issue_rs2] && !bypass2;
  // A writeback landing this cycle is ordered before the new write, so WAW always clears.
  assign waw  = i_issue_rd_wen && (i_issue_rd != 5'd0) && busy_q[i_issue_rd]
                && !(clr && (i_wb_rd == i_issue_rd));
  // A retiring write frees a slot in the same cycle, so the count cannot exceed the limit.
  assign full = track && (inflight_q == MAX_CNT) && !clr;

  assign o_issue_ready = !i_rst && !(raw1 || raw2 || waw || full);

  assign fire = i_issue_valid && o_issue_ready;
  assign set  = fire && track;

  // Next busy vector: clear first so a same-register set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr) busy_d[i_wb_rd] = 1'b0;
    if (set) busy_d[i_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Next outstanding count: simultaneous set and clear cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (set && !clr) begin
      inflight_d = inflight_q + 4'd1;
    end else if (clr && !set) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  // State registers; reset discards all tracking and the sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      if (i_wb_valid && !clr) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Purpose: directed self-checking bench for rf_scoreboard, both bypass settings driven in lockstep.
// Latency: checks combinational ready 2 time units after each rising edge, registered state after the edge.
// Backpressure: reader probes in writeback cycles keep valid low so both instances hold identical state.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, rs1_ren, rs2_ren, rd_wen, issue_long, wb_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        ready0, ready1, err0, err1;
  logic [31:0] busy0, busy1;
  logic [3:0]  inflight0, inflight1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.BYPASS_EN(1'b0), .MAX_INFLIGHT(4)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_issue_valid(issue_valid),
    .i_issue_rs1_ren(rs1_ren), .i_issue_rs1(rs1),
    .i_issue_rs2_ren(rs2_ren), .i_issue_rs2(rs2),
    .i_issue_rd_wen(rd_wen), .i_issue_rd(rd),
    .i_issue_long(issue_long),
    .o_issue_ready(ready0),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .o_busy(busy0), .o_inflight(inflight0), .o_err(err0)
  );

  rf_scoreboard #(.BYPASS_EN(1'b1), .MAX_INFLIGHT(4)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_issue_valid(issue_valid),
    .i_issue_rs1_ren(rs1_ren), .i_issue_rs1(rs1),
    .i_issue_rs2_ren(rs2_ren), .i_issue_rs2(rs2),
    .i_issue_rd_wen(rd_wen), .i_issue_rd(rd),
    .i_issue_long(issue_long),
    .o_issue_ready(ready1),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .o_busy(busy1), .o_inflight(inflight1), .o_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then leave 1 time unit before driving new inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after changing inputs.
  task automatic settle();
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic r1en, input logic [4:0] r1,
                             input logic r2en, input logic [4:0] r2,
                             input logic dwen, input logic [4:0] d, input logic lng);
    issue_valid = v;
    rs1_ren = r1en; rs1 = r1;
    rs2_ren = r2en; rs2 = r2;
    rd_wen = dwen;  rd = d;
    issue_long = lng;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] r);
    wb_valid = v;
    wb_rd = r;
  endtask

  task automatic idle();
    drive_issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_wb(1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset: ready held low even for a hazard-free reader.
    drive_issue(1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd0);
    step();
    step();
    chk("rst_busy", busy0, 32'd0);
    chk("rst_inflight", {28'd0, inflight0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);

    // Idle: non-long instruction never stalls and leaves no state.
    rst = 1'b0;
    drive_issue(1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0);
    settle();
    chk("idle_ready0", {31'd0, ready0}, 32'd1);
    chk("idle_ready1", {31'd0, ready1}, 32'd1);
    step();
    idle();
    settle();
    chk("idle_busy", busy0, 32'd0);
    chk("idle_inflight", {28'd0, inflight0}, 32'd0);

    // RAW: long write to x3, then a reader of x3.
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
    settle();
    chk("raw_issue_ready", {31'd0, ready0}, 32'd1);
    step();
    drive_issue(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    chk("raw_busy", busy0, 32'h8);
    chk("raw_inflight", {28'd0, inflight0}, 32'd1);
    chk("raw_stall0", {31'd0, ready0}, 32'd0);
    chk("raw_stall1", {31'd0, ready1}, 32'd0);
    // rs2 path hazard too.
    drive_issue(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    settle();
    chk("raw_rs2_stall", {31'd0, ready0}, 32'd0);
    step();
    drive_issue(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_wb(1'b1, 5'd3);
    settle();
    chk("raw_wb_cycle_nobypass", {31'd0, ready0}, 32'd0);
    chk("raw_wb_cycle_bypass", {31'd0, ready1}, 32'd1);
    step();
    drive_wb(1'b0, 5'd0);
    settle();
    chk("raw_after_wb_nobypass", {31'd0, ready0}, 32'd1);
    chk("raw_after_busy", busy0, 32'd0);
    chk("raw_after_inflight", {28'd0, inflight0}, 32'd0);
    chk("raw_bypass_busy", busy1, 32'd0);

    // WAW and simultaneous set/clear on x9.
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
    step();
    settle();
    chk("waw_busy", busy0, 32'h200);
    chk("waw_stall", {31'd0, ready0}, 32'd0);
    drive_wb(1'b1, 5'd9);
    settle();
    chk("waw_release0", {31'd0, ready0}, 32'd1);
    chk("waw_release1", {31'd0, ready1}, 32'd1);
    step();
    idle();
    settle();
    chk("simul_busy", busy0, 32'h200);
    chk("simul_inflight", {28'd0, inflight0}, 32'd1);
    drive_wb(1'b1, 5'd9);
    step();
    idle();
    settle();
    chk("waw_clean_busy", busy0, 32'd0);
    chk("waw_clean_err", {31'd0, err0}, 32'd0);

    // Full: four long writes to x1..x4.
    for (int r = 1; r <= 4; r++) begin
      drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(r), 1'b1);
      step();
    end
    idle();
    settle();
    chk("full_inflight", {28'd0, inflight0}, 32'd4);
    chk("full_busy", busy0, 32'h1E);
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
    settle();
    chk("full_stall", {31'd0, ready0}, 32'd0);
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    settle();
    chk("full_short_ok", {31'd0, ready0}, 32'd1);
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
    drive_wb(1'b1, 5'd1);
    settle();
    chk("full_wb_release", {31'd0, ready0}, 32'd1);
    step();
    idle();
    settle();
    chk("full_swap_inflight", {28'd0, inflight0}, 32'd4);
    chk("full_swap_busy", busy0, 32'h3C);

    // Error: writeback to a non-busy x12 leaves state alone.
    drive_wb(1'b1, 5'd12);
    step();
    idle();
    settle();
    chk("err_x12", {31'd0, err0}, 32'd1);
    chk("err_x12_busy", busy0, 32'h3C);
    chk("err_x12_inflight", {28'd0, inflight0}, 32'd4);

    // Retire x3..x5 and add x1 to reach busy = 0x6, inflight = 2.
    for (int r = 3; r <= 5; r++) begin
      drive_wb(1'b1, 5'(r));
      step();
    end
    drive_wb(1'b0, 5'd0);
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1);
    step();
    idle();
    settle();
    chk("pre_rst_busy", busy0, 32'h6);
    chk("pre_rst_inflight", {28'd0, inflight0}, 32'd2);
    chk("err_sticky", {31'd0, err0}, 32'd1);

    // Reset mid-flight; issue and writeback during reset are ignored.
    rst = 1'b1;
    drive_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
    drive_wb(1'b1, 5'd1);
    settle();
    chk("rst_mid_ready", {31'd0, ready0}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    drive_issue(1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    chk("post_rst_busy", busy0, 32'd0);
    chk("post_rst_inflight", {28'd0, inflight0}, 32'd0);
    chk("post_rst_err", {31'd0, err0}, 32'd0);
    chk("post_rst_ready", {31'd0, ready0}, 32'd1);

    // x0 is never tracked, and a writeback to x0 is an error.
    drive_issue(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    step();
    idle();
    settle();
    chk("x0_no_track_busy", busy0, 32'd0);
    chk("x0_no_track_inflight", {28'd0, inflight0}, 32'd0);
    drive_wb(1'b1, 5'd0);
    step();
    idle();
    settle();
    chk("err_x0", {31'd0, err0}, 32'd1);
    chk("err_x0_bypass_dut", {31'd0, err1}, 32'd1);
    chk("err_x0_busy", busy0, 32'd0);
    chk("err_x0_inflight", {28'd0, inflight1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
